// File: rtl/apb_timer_nch.sv
// N-channel APB down-counter timer with per-channel reload, free-run/user/one-shot modes,
// maskable level interrupts and ETB start/stop/expiry triggers.
module apb_timer_nch #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 32
) (
  input  logic              pclk,
  input  logic              presetn,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [7:0]        paddr,
  input  logic [31:0]       pwdata,
  output logic [31:0]       prdata,
  input  logic [NUM_CH-1:0] etb_trig_en_on,
  input  logic [NUM_CH-1:0] etb_trig_en_off,
  output logic [NUM_CH-1:0] tim_etb_trig,
  output logic [NUM_CH-1:0] intr,
  input  logic              scan_mode
);

  logic [NUM_CH-1:0][CNT_W-1:0] load_q, load_d, cur_q, cur_d;
  logic [NUM_CH-1:0]            en_q, en_d, mode_q, mode_d, mask_q, mask_d;
  logic [NUM_CH-1:0]            oneshot_q, oneshot_d, raw_q, raw_d;
  logic [NUM_CH-1:0]            trig_q, trig_d, start_q, start_d;
  logic [NUM_CH-1:0]            ch_hit_s, ld_wr_s, ctrl_wr_s, eoi_clr_s, expire_s;
  logic [NUM_CH-1:0][31:0]      ch_rd_s;
  logic                         wr_s, rd_acc_s, eoi_all_s;
  logic                         unused_s;

  assign wr_s      = psel & penable & pwrite;
  assign rd_acc_s  = psel & penable & ~pwrite;
  assign eoi_all_s = rd_acc_s & (paddr[7:2] == 6'h21);
  assign unused_s  = ^{scan_mode, pwdata, paddr[1:0]};

  // Address decode and per-channel read values.
  always_comb begin
    ch_hit_s  = '0;
    ld_wr_s   = '0;
    ctrl_wr_s = '0;
    eoi_clr_s = '0;
    ch_rd_s   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      ch_hit_s[i]  = ~paddr[7] & (paddr[6:4] == 3'(i));
      ld_wr_s[i]   = wr_s & ch_hit_s[i] & (paddr[3:2] == 2'd0);
      ctrl_wr_s[i] = wr_s & ch_hit_s[i] & (paddr[3:2] == 2'd2);
      eoi_clr_s[i] = (rd_acc_s & ch_hit_s[i] & (paddr[3:2] == 2'd3)) | eoi_all_s;
      case (paddr[3:2])
        2'd0:    ch_rd_s[i] = 32'(load_q[i]);
        2'd1:    ch_rd_s[i] = 32'(cur_q[i]);
        2'd2:    ch_rd_s[i] = {28'h0, oneshot_q[i], mask_q[i], mode_q[i], en_q[i]};
        2'd3:    ch_rd_s[i] = {31'h0, raw_q[i]};
        default: ch_rd_s[i] = 32'h0;
      endcase
    end
  end

  // Per-channel next state: control, enable arbitration, counter and raw flag.
  always_comb begin
    load_d    = load_q;
    cur_d     = cur_q;
    en_d      = en_q;
    mode_d    = mode_q;
    mask_d    = mask_q;
    oneshot_d = oneshot_q;
    raw_d     = raw_q;
    trig_d    = '0;
    start_d   = '0;
    expire_s  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      // start_q marks the load edge right after EN rises; it suppresses expiry on that edge.
      expire_s[i] = en_q[i] & ~start_q[i] & (cur_q[i] == {CNT_W{1'b0}});

      if (ld_wr_s[i]) load_d[i] = pwdata[CNT_W-1:0];
      else            load_d[i] = load_q[i];

      if (ctrl_wr_s[i]) begin
        mode_d[i]    = pwdata[1];
        mask_d[i]    = pwdata[2];
        oneshot_d[i] = pwdata[3];
      end else begin
        mode_d[i]    = mode_q[i];
        mask_d[i]    = mask_q[i];
        oneshot_d[i] = oneshot_q[i];
      end

      if (etb_trig_en_off[i])                 en_d[i] = 1'b0;
      else if (etb_trig_en_on[i])             en_d[i] = 1'b1;
      else if (ctrl_wr_s[i])                  en_d[i] = pwdata[0];
      else if (expire_s[i] && oneshot_q[i])   en_d[i] = 1'b0;
      else                                    en_d[i] = en_q[i];
      start_d[i] = en_d[i] & ~en_q[i];

      if (!en_q[i])          cur_d[i] = cur_q[i];
      else if (start_q[i])   cur_d[i] = load_q[i];
      else if (expire_s[i]) begin
        if (oneshot_q[i])    cur_d[i] = {CNT_W{1'b0}};
        else if (mode_q[i])  cur_d[i] = load_q[i];
        else                 cur_d[i] = {CNT_W{1'b1}};
      end else               cur_d[i] = cur_q[i] - {{(CNT_W-1){1'b0}}, 1'b1};

      trig_d[i] = expire_s[i];
      if (expire_s[i])       raw_d[i] = 1'b1;
      else if (eoi_clr_s[i]) raw_d[i] = 1'b0;
      else                   raw_d[i] = raw_q[i];
    end
  end

  // State registers.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      load_q    <= '0;
      cur_q     <= '0;
      en_q      <= '0;
      mode_q    <= '0;
      mask_q    <= '0;
      oneshot_q <= '0;
      raw_q     <= '0;
      trig_q    <= '0;
      start_q   <= '0;
    end else begin
      load_q    <= load_d;
      cur_q     <= cur_d;
      en_q      <= en_d;
      mode_q    <= mode_d;
      mask_q    <= mask_d;
      oneshot_q <= oneshot_d;
      raw_q     <= raw_d;
      trig_q    <= trig_d;
      start_q   <= start_d;
    end
  end

  // Read mux; global and channel windows are disjoint, so channel hits are OR-ed in.
  always_comb begin
    prdata = 32'h0;
    if (psel && !pwrite) begin
      case (paddr[7:2])
        6'h20, 6'h21: prdata = 32'(raw_q & ~mask_q);
        6'h22:        prdata = 32'(raw_q);
        default:      prdata = 32'h0;
      endcase
      for (int i = 0; i < NUM_CH; i++) begin
        prdata = prdata | (ch_hit_s[i] ? ch_rd_s[i] : 32'h0);
      end
    end else begin
      prdata = 32'h0;
    end
  end

  assign intr         = raw_q & ~mask_q;
  assign tim_etb_trig = trig_q;

endmodule
